// File: rtl/image_rx_if.sv
// rtl/image_rx_if.sv - image_rx image word, pixel stream and label handshake bundle
//
// Purpose: groups every image_rx handshake signal so the design and its
// environment connect through one port. clk and reset stay plain ports.
// Signal summary:
//   enable, pause           phase control from the host
//   img_request/input_valid/image   32-bit image word handshake
//   label_request/label_in/label_out    label fetch and captured label
//   pix_valid/pix_ready/pixel/pix_index/pix_last  pixel output stream
//   img_done, proto_err     completion pulse and sticky protocol error
// modport slave  : image_rx side
// modport master : host/environment side
interface image_rx_if;
    logic        enable;
    logic        pause;
    logic        img_request;
    logic        input_valid;
    logic [31:0] image;
    logic        label_request;
    logic [3:0]  label_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pixel;
    logic [9:0]  pix_index;
    logic        pix_last;
    logic [3:0]  label_out;
    logic        img_done;
    logic        proto_err;

    modport slave (
        input  enable, pause, input_valid, image, label_in, pix_ready,
        output img_request, label_request, pix_valid, pixel, pix_index,
               pix_last, label_out, img_done, proto_err
    );

    modport master (
        output enable, pause, input_valid, image, label_in, pix_ready,
        input  img_request, label_request, pix_valid, pixel, pix_index,
               pix_last, label_out, img_done, proto_err
    );
endinterface

// File: rtl/image_rx.sv
// rtl/image_rx.sv - receives packed image words, unpacks pixels, fetches the image label
//
// Purpose: requests WORDS_PER_IMG 32-bit words, buffers up to two, emits
// PIX_PER_WORD 8-bit pixels per word MSB-first with a running index, then
// requests and captures the image label and pulses img_done.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    image_rx_if.slave (see rtl/image_rx_if.sv)
module image_rx #(
    parameter int WORDS_PER_IMG = 196,
    parameter int PIX_PER_WORD  = 4
) (
    input  logic        clk,
    input  logic        reset,
    image_rx_if.slave   bus
);
    localparam int TOTAL_PIX = WORDS_PER_IMG * PIX_PER_WORD;
    localparam int WCNT_W    = $clog2(WORDS_PER_IMG + 1);
    localparam int SUB_W     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [WCNT_W-1:0] WORDS_MAX = WCNT_W'(WORDS_PER_IMG);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(PIX_PER_WORD - 1);
    localparam logic [9:0]        IDX_LAST  = 10'(TOTAL_PIX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_LBL_REQ,
        S_LBL_CAP,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [31:0]       r_buf [2];      // r_buf[0] is always the head word
    logic [1:0]        r_occ;
    logic [WCNT_W-1:0] r_words;
    logic [SUB_W-1:0]  r_sub;          // pixel position inside the head word
    logic [9:0]        r_pix_index;
    logic [3:0]        r_label;
    logic              r_label_request;
    logic              r_img_done;
    logic              r_proto_err;

    logic              w_img_request;
    logic              w_push;
    logic              w_pix_valid;
    logic              w_xfer;
    logic              w_pop;
    logic [1:0]        w_wr_slot;
    int                w_shift;
    logic [7:0]        w_pixel;
    logic              w_start;

    assign w_img_request = (r_state == S_RECV) && !bus.pause &&
                           (r_words < WORDS_MAX) && (r_occ < 2'd2);
    assign w_push        = w_img_request && bus.input_valid;
    assign w_pix_valid   = (r_occ != 2'd0);
    assign w_xfer        = w_pix_valid && bus.pix_ready;
    assign w_pop         = w_xfer && (r_sub == SUB_LAST);
    // A simultaneous pop shifts entry 1 down, so the new word lands one slot lower.
    assign w_wr_slot     = r_occ - {1'b0, w_pop};
    // MSB-first: sub-position 0 selects the top byte of the head word.
    assign w_shift       = 8 * (PIX_PER_WORD - 1 - int'(r_sub));
    assign w_pixel       = w_pix_valid ? 8'(r_buf[0] >> w_shift) : 8'd0;
    assign w_start       = bus.enable && !bus.pause;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_buf[0]        <= '0;
            r_buf[1]        <= '0;
            r_occ           <= '0;
            r_words         <= '0;
            r_sub           <= '0;
            r_pix_index     <= '0;
            r_label         <= '0;
            r_label_request <= 1'b0;
            r_img_done      <= 1'b0;
            r_proto_err     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_buf[0] <= r_buf[1];
            end
            if (w_push) begin
                r_buf[w_wr_slot[0]] <= bus.image;
                r_words <= r_words + 1'b1;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};

            if (bus.input_valid && !w_img_request) begin
                r_proto_err <= 1'b1;
            end

            if (w_xfer) begin
                r_sub <= w_pop ? '0 : r_sub + 1'b1;
                // Hold at the last index rather than wrap; cleared on next image start.
                if (r_pix_index != IDX_LAST) begin
                    r_pix_index <= r_pix_index + 1'b1;
                end
            end

            r_label_request <= 1'b0;
            r_img_done      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_RECV;
                        r_words     <= '0;
                        r_sub       <= '0;
                        r_pix_index <= '0;
                    end
                end
                S_RECV: begin
                    // enable is ignored here so an image in flight always completes.
                    if (w_xfer && (r_pix_index == IDX_LAST)) begin
                        r_state         <= S_LBL_REQ;
                        r_label_request <= 1'b1;
                    end
                end
                S_LBL_REQ: begin
                    r_state <= S_LBL_CAP;
                end
                S_LBL_CAP: begin
                    r_label    <= bus.label_in;
                    r_state    <= S_DONE;
                    r_img_done <= 1'b1;
                end
                S_DONE: begin
                    if (w_start) begin
                        r_state     <= S_RECV;
                        r_words     <= '0;
                        r_sub       <= '0;
                        r_pix_index <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.img_request   = w_img_request;
    assign bus.label_request = r_label_request;
    assign bus.pix_valid     = w_pix_valid;
    assign bus.pixel         = w_pixel;
    assign bus.pix_index     = r_pix_index;
    assign bus.pix_last      = w_pix_valid && (r_pix_index == IDX_LAST);
    assign bus.label_out     = r_label;
    assign bus.img_done      = r_img_done;
    assign bus.proto_err     = r_proto_err;
endmodule

// File: tb/tb_image_rx.sv
// tb/tb_image_rx.sv - directed self-checking bench for image_rx
module tb_image_rx;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   words_fed;

    image_rx_if bus ();

    image_rx #(.WORDS_PER_IMG(196), .PIX_PER_WORD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Word w carries pixels 4w..4w+3 (mod 256), so pixel value equals index[7:0].
    function automatic logic [31:0] word_of(int w);
        word_of = {8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)};
    endfunction

    // Records handshake activity seen before the edge, then advances one cycle.
    task automatic tick(output bit xf, output logic [7:0] px, output logic [9:0] ix,
                        output bit lst, output bit push, output bit lreq, output bit done);
        xf   = bus.pix_valid & bus.pix_ready;
        px   = bus.pixel;
        ix   = bus.pix_index;
        lst  = bus.pix_last;
        push = bus.img_request & bus.input_valid;
        lreq = bus.label_request;
        done = bus.img_done;
        @(posedge clk);
        #1;
        if (push) words_fed++;
    endtask

    task automatic do_reset();
        bit xf, lst, push, lreq, done;
        logic [7:0] px;
        logic [9:0] ix;
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.pause = 1'b0;
        bus.input_valid = 1'b0;
        bus.image = '0;
        bus.label_in = '0;
        bus.pix_ready = 1'b0;
        tick(xf, px, ix, lst, push, lreq, done);
        tick(xf, px, ix, lst, push, lreq, done);
        reset = 1'b0;
        words_fed = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.img_request !== 1'b0) begin failures++; $display("FAIL rst_img_request: got %0b expected 0", bus.img_request); end
        checks++; if (bus.label_request !== 1'b0) begin failures++; $display("FAIL rst_label_request: got %0b expected 0", bus.label_request); end
        checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL rst_pix_valid: got %0b expected 0", bus.pix_valid); end
        checks++; if (bus.pixel !== 8'd0) begin failures++; $display("FAIL rst_pixel: got %0h expected 0", bus.pixel); end
        checks++; if (bus.pix_index !== 10'd0) begin failures++; $display("FAIL rst_pix_index: got %0d expected 0", bus.pix_index); end
        checks++; if (bus.pix_last !== 1'b0) begin failures++; $display("FAIL rst_pix_last: got %0b expected 0", bus.pix_last); end
        checks++; if (bus.label_out !== 4'd0) begin failures++; $display("FAIL rst_label_out: got %0h expected 0", bus.label_out); end
        checks++; if (bus.img_done !== 1'b0) begin failures++; $display("FAIL rst_img_done: got %0b expected 0", bus.img_done); end
        checks++; if (bus.proto_err !== 1'b0) begin failures++; $display("FAIL rst_proto_err: got %0b expected 0", bus.proto_err); end
    endtask

    task automatic test_full_image();
        bit xf, lst, push, lreq, done;
        logic [7:0] px;
        logic [9:0] ix;
        int exp_idx = 0, seq_err = 0, nlast = 0, last_at = -1, nlreq = 0, ndone = 0, cyc = 0, post = 0;
        bit done_seen = 0;
        do_reset();
        bus.label_in = 4'd7;
        bus.pix_ready = 1'b1;
        bus.input_valid = 1'b1;
        bus.enable = 1'b1;
        while (cyc < 3000 && !(done_seen && post >= 5)) begin
            bus.image = word_of(words_fed);
            if (exp_idx >= 10) bus.enable = 1'b0;
            tick(xf, px, ix, lst, push, lreq, done);
            cyc++;
            if (done_seen) post++;
            if (xf) begin
                if (px !== 8'(exp_idx) || ix !== 10'(exp_idx)) seq_err++;
                if (lst) begin nlast++; last_at = int'(ix); end
                exp_idx++;
            end
            if (lreq) nlreq++;
            if (done) begin ndone++; done_seen = 1; end
        end
        checks++; if (!done_seen) begin failures++; $display("FAIL full_timeout: got no img_done expected img_done within 3000 cycles"); end
        checks++; if (exp_idx != 784) begin failures++; $display("FAIL full_pix_count: got %0d expected 784", exp_idx); end
        checks++; if (seq_err != 0) begin failures++; $display("FAIL full_pix_seq: got %0d bad pixels expected 0", seq_err); end
        checks++; if (nlast != 1 || last_at != 783) begin failures++; $display("FAIL full_pix_last: got %0d at %0d expected 1 at 783", nlast, last_at); end
        checks++; if (nlreq != 1) begin failures++; $display("FAIL full_label_request: got %0d expected 1", nlreq); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL full_img_done: got %0d expected 1", ndone); end
        checks++; if (bus.label_out !== 4'd7) begin failures++; $display("FAIL full_label_out: got %0h expected 7", bus.label_out); end
        checks++; if (words_fed != 196) begin failures++; $display("FAIL full_words: got %0d expected 196", words_fed); end
        checks++; if (bus.img_request !== 1'b0) begin failures++; $display("FAIL full_idle_after: got %0b expected 0", bus.img_request); end
    endtask

    task automatic test_unpack_stall();
        bit xf, lst, push, lreq, done;
        logic [7:0] px;
        logic [9:0] ix;
        logic [7:0] exp_px [8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h11, 8'h22, 8'h33, 8'h44};
        int hold_err = 0, seq_err = 0;
        logic req_after_pop = 1'b0;
        do_reset();
        bus.enable = 1'b1;
        tick(xf, px, ix, lst, push, lreq, done);
        checks++; if (bus.img_request !== 1'b1) begin failures++; $display("FAIL us_req_recv: got %0b expected 1", bus.img_request); end
        bus.image = 32'hA1B2C3D4;
        bus.input_valid = 1'b1;
        tick(xf, px, ix, lst, push, lreq, done);
        checks++; if (bus.pix_valid !== 1'b1 || bus.pixel !== 8'hA1 || bus.pix_index !== 10'd0) begin
            failures++; $display("FAIL us_latency: got v=%0b px=%0h ix=%0d expected v=1 px=a1 ix=0", bus.pix_valid, bus.pixel, bus.pix_index); end
        bus.image = 32'h11223344;
        tick(xf, px, ix, lst, push, lreq, done);
        bus.input_valid = 1'b0;
        checks++; if (bus.img_request !== 1'b0) begin failures++; $display("FAIL us_full_req: got %0b expected 0", bus.img_request); end
        for (int i = 0; i < 10; i++) begin
            tick(xf, px, ix, lst, push, lreq, done);
            if (bus.pixel !== 8'hA1 || bus.pix_index !== 10'd0 || bus.pix_valid !== 1'b1 || bus.img_request !== 1'b0) hold_err++;
        end
        checks++; if (hold_err != 0) begin failures++; $display("FAIL us_stall_hold: got %0d bad cycles expected 0", hold_err); end
        bus.pix_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (bus.pixel !== exp_px[j] || bus.pix_index !== 10'(j) || bus.pix_valid !== 1'b1) seq_err++;
            if (j == 4) req_after_pop = bus.img_request;
            tick(xf, px, ix, lst, push, lreq, done);
        end
        checks++; if (seq_err != 0) begin failures++; $display("FAIL us_unpack_seq: got %0d bad pixels expected 0", seq_err); end
        checks++; if (req_after_pop !== 1'b1) begin failures++; $display("FAIL us_req_after_pop: got %0b expected 1", req_after_pop); end
        checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL us_drained: got %0b expected 0", bus.pix_valid); end
        checks++; if (bus.proto_err !== 1'b0) begin failures++; $display("FAIL us_proto_err: got %0b expected 0", bus.proto_err); end
    endtask

    task automatic test_pause();
        bit xf, lst, push, lreq, done;
        logic [7:0] px;
        logic [9:0] ix;
        int exp_idx = 0, seq_err = 0, cyc = 0, ph = 0, pcnt = 0, pause_push = 0, pause_xf = 0, ndone = 0;
        logic resume_req = 1'b0;
        bit resume_checked = 0;
        do_reset();
        bus.label_in = 4'hC;
        bus.pix_ready = 1'b1;
        bus.enable = 1'b1;
        while (cyc < 3000 && ndone == 0) begin
            bus.image = word_of(words_fed);
            if (exp_idx >= 300) bus.enable = 1'b0;
            if (ph == 0 && exp_idx >= 100) begin ph = 1; pcnt = 0; end
            if (ph == 1 && pcnt == 20) ph = 2;
            bus.pause = (ph == 1);
            #1;
            if (ph == 2 && !resume_checked) begin resume_req = bus.img_request; resume_checked = 1; end
            bus.input_valid = bus.img_request;
            tick(xf, px, ix, lst, push, lreq, done);
            cyc++;
            if (ph == 1) begin pcnt++; if (push) pause_push++; if (xf) pause_xf++; end
            if (xf) begin
                if (px !== 8'(exp_idx) || ix !== 10'(exp_idx)) seq_err++;
                exp_idx++;
            end
            if (done) ndone++;
        end
        bus.input_valid = 1'b0;
        checks++; if (pause_push != 0) begin failures++; $display("FAIL pz_no_accept: got %0d words expected 0", pause_push); end
        checks++; if (pause_xf == 0) begin failures++; $display("FAIL pz_drain: got 0 pixels expected >0"); end
        checks++; if (resume_req !== 1'b1) begin failures++; $display("FAIL pz_resume_req: got %0b expected 1", resume_req); end
        checks++; if (seq_err != 0 || exp_idx != 784) begin failures++; $display("FAIL pz_seq: got %0d bad of %0d expected 0 of 784", seq_err, exp_idx); end
        checks++; if (ndone != 1 || bus.label_out !== 4'hC) begin failures++; $display("FAIL pz_done: got done=%0d label=%0h expected 1 c", ndone, bus.label_out); end
        checks++; if (bus.proto_err !== 1'b0) begin failures++; $display("FAIL pz_proto_err: got %0b expected 0", bus.proto_err); end
    endtask

    task automatic test_proto_and_reset();
        bit xf, lst, push, lreq, done;
        logic [7:0] px;
        logic [9:0] ix;
        do_reset();
        bus.input_valid = 1'b1;
        bus.image = 32'hDEADBEEF;
        tick(xf, px, ix, lst, push, lreq, done);
        bus.input_valid = 1'b0;
        checks++; if (bus.proto_err !== 1'b1) begin failures++; $display("FAIL pr_set: got %0b expected 1", bus.proto_err); end
        checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL pr_discard: got %0b expected 0", bus.pix_valid); end
        bus.enable = 1'b1;
        bus.pix_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.image = word_of(words_fed);
            bus.input_valid = bus.img_request;
            tick(xf, px, ix, lst, push, lreq, done);
        end
        checks++; if (bus.proto_err !== 1'b1 || bus.pix_index === 10'd0) begin
            failures++; $display("FAIL pr_sticky_mid: got err=%0b ix=%0d expected err=1 ix>0", bus.proto_err, bus.pix_index); end
        reset = 1'b1;
        tick(xf, px, ix, lst, push, lreq, done);
        checks++; if (bus.img_request !== 1'b0 || bus.pix_valid !== 1'b0 || bus.pixel !== 8'd0 || bus.pix_index !== 10'd0 ||
                      bus.pix_last !== 1'b0 || bus.label_request !== 1'b0 || bus.img_done !== 1'b0 || bus.proto_err !== 1'b0 ||
                      bus.label_out !== 4'd0) begin
            failures++; $display("FAIL pr_mid_reset: got req=%0b v=%0b px=%0h ix=%0d err=%0b expected all 0",
                                 bus.img_request, bus.pix_valid, bus.pixel, bus.pix_index, bus.proto_err); end
        reset = 1'b0;
        bus.input_valid = 1'b0;
        tick(xf, px, ix, lst, push, lreq, done);
        bus.image = 32'h55667788;
        bus.input_valid = 1'b1;
        tick(xf, px, ix, lst, push, lreq, done);
        bus.input_valid = 1'b0;
        checks++; if (bus.pix_index !== 10'd0 || bus.pixel !== 8'h55 || bus.pix_valid !== 1'b1) begin
            failures++; $display("FAIL pr_restart: got ix=%0d px=%0h v=%0b expected ix=0 px=55 v=1", bus.pix_index, bus.pixel, bus.pix_valid); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        words_fed = 0;
        reset = 1'b1;
        test_reset();
        test_full_image();
        test_unpack_stall();
        test_pause();
        test_proto_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
